// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard unit with EX/MEM shadow slots.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module forward_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  IDValid,
  input  logic [REG_ADDR_W-1:0] IDRs,
  input  logic [REG_ADDR_W-1:0] IDRt,
  input  logic                  IDUseRs,
  input  logic                  IDUseRt,
  input  logic [REG_ADDR_W-1:0] IDWriteRegAddr,
  input  logic                  IDRegWrite,
  input  logic                  IDMemToReg,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [1:0]            Forward1,
  output logic [1:0]            Forward2,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FwdCount
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic                  reg_write;
    logic                  mem_to_reg;
  } slot_t;

  slot_t      ex_s, mem_s, ex_nxt;
  logic [1:0] fwd1_nxt, fwd2_nxt;
  logic       issue;

  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] src);
    return s.valid & s.reg_write & (s.addr == src) & (src != ZERO_ADDR);
  endfunction

  // Youngest producer (EX slot) takes priority over the MEM slot.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_ADDR_W-1:0] src,
                                         input slot_t ex_q, input slot_t mem_q);
    if (use_src && slot_match(ex_q, src))       return FWD_MEM;
    else if (use_src && slot_match(mem_q, src)) return FWD_WB;
    else                                        return FWD_REG;
  endfunction

  always_comb begin
    Stall    = 1'b0;
    issue    = 1'b0;
    ex_nxt   = '0;
    fwd1_nxt = FWD_REG;
    fwd2_nxt = FWD_REG;

    Stall = IDValid & ~Flush & ex_s.mem_to_reg &
            ((IDUseRs & slot_match(ex_s, IDRs)) | (IDUseRt & slot_match(ex_s, IDRt)));
    issue = IDValid & ~Flush & ~Stall;

    if (issue) begin
      ex_nxt.valid      = 1'b1;
      ex_nxt.addr       = IDWriteRegAddr;
      ex_nxt.reg_write  = IDRegWrite;
      ex_nxt.mem_to_reg = IDMemToReg;
      fwd1_nxt          = fwd_sel(IDUseRs, IDRs, ex_s, mem_s);
      fwd2_nxt          = fwd_sel(IDUseRt, IDRt, ex_s, mem_s);
    end
  end

  // Shadow slots and registered forward selects.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      ex_s     <= '0;
      mem_s    <= '0;
      Forward1 <= FWD_REG;
      Forward2 <= FWD_REG;
    end else begin
      mem_s    <= ex_s;
      ex_s     <= ex_nxt;
      Forward1 <= fwd1_nxt;
      Forward2 <= fwd2_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic fwd_any;
  assign fwd_any = issue & ((fwd1_nxt != FWD_REG) | (fwd2_nxt != FWD_REG));

  // Saturating statistics counters.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      StallCount <= '0;
      FwdCount   <= '0;
    end else begin
      if (Stall && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + CNT_W'(1);
      if (fwd_any && (FwdCount != {CNT_W{1'b1}})) FwdCount <= FwdCount + CNT_W'(1);
    end
  end
`else
  assign StallCount = '0;
  assign FwdCount   = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed cases plus random traffic
// compared against an in-flight instruction history model.
module tb_forward_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 32;

  logic          Clk, RstN;
  logic          IDValid, IDUseRs, IDUseRt, IDRegWrite, IDMemToReg, Flush;
  logic [AW-1:0] IDRs, IDRt, IDWriteRegAddr;
  logic          Stall;
  logic [1:0]    Forward1, Forward2;
  logic [CW-1:0] StallCount, FwdCount;

  forward_hazard_unit #(.REG_ADDR_W(AW), .ZERO_REG(0), .CNT_W(CW)) dut (
    .Clk(Clk), .RstN(RstN), .IDValid(IDValid), .IDRs(IDRs), .IDRt(IDRt),
    .IDUseRs(IDUseRs), .IDUseRt(IDUseRt), .IDWriteRegAddr(IDWriteRegAddr),
    .IDRegWrite(IDRegWrite), .IDMemToReg(IDMemToReg), .Flush(Flush),
    .Stall(Stall), .Forward1(Forward1), .Forward2(Forward2),
    .StallCount(StallCount), .FwdCount(FwdCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] wa;
    logic       rw, mr, fl;
  } instr_t;

  // History of issued instructions: index 0 = now in EX, 1 = now in MEM.
  instr_t hist [2];
  int     n_checks, n_errors;
  int     m_stalls, m_fwds;
  logic   last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input int rs, input int rt, input logic urs,
                                input logic urt, input int wa, input logic rw,
                                input logic mr, input logic fl);
    instr_t i;
    i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
    i.wa = 5'(wa); i.rw = rw; i.mr = mr; i.fl = fl;
    return i;
  endfunction

  function automatic bit writes_reg(input instr_t p, input logic [4:0] r);
    return p.v && p.rw && r != 0 && p.wa == r;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic u, input logic [4:0] r);
    if (!u) return 2'd0;
    for (int age = 0; age < 2; age++)
      if (writes_reg(hist[age], r)) return (age == 0) ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  function automatic logic exp_stall(input instr_t i);
    if (!i.v || i.fl || !hist[0].mr) return 1'b0;
    return (i.urs && writes_reg(hist[0], i.rs)) || (i.urt && writes_reg(hist[0], i.rt));
  endfunction

  task automatic model_reset();
    hist[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hist[1] = hist[0];
    m_stalls = 0;
    m_fwds = 0;
  endtask

  task automatic drive(input instr_t i);
    IDValid = i.v; IDRs = i.rs; IDRt = i.rt; IDUseRs = i.urs; IDUseRt = i.urt;
    IDWriteRegAddr = i.wa; IDRegWrite = i.rw; IDMemToReg = i.mr; Flush = i.fl;
  endtask

  task automatic check_stats();
`ifdef HAZARD_STATS_EN
    check("stall_count", StallCount, 32'(m_stalls));
    check("fwd_count", FwdCount, 32'(m_fwds));
`else
    check("stall_count_tied", StallCount, 32'd0);
    check("fwd_count_tied", FwdCount, 32'd0);
`endif
  endtask

  // One ID evaluation: check Stall, clock, then check the selects seen in EX.
  task automatic cycle(input instr_t i);
    logic       st;
    logic [1:0] f1, f2;
    drive(i);
    #1;
    st = exp_stall(i);
    last_stall = st;
    check("stall", 32'(Stall), 32'(st));
    if (i.v && !i.fl && !st) begin
      f1 = exp_fwd(i.urs, i.rs);
      f2 = exp_fwd(i.urt, i.rt);
    end else begin
      f1 = 2'd0;
      f2 = 2'd0;
    end
    @(posedge Clk);
    if (st) m_stalls++;
    if (f1 != 0 || f2 != 0) m_fwds++;
    hist[1] = hist[0];
    hist[0] = (i.v && !i.fl && !st) ? i : mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("fwd1", 32'(Forward1), 32'(f1));
    check("fwd2", 32'(Forward2), 32'(f2));
  endtask

  task automatic do_reset();
    RstN = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge Clk);
    #2;
    RstN = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  instr_t nop, add3, lw2, use2;

  initial begin
    n_checks = 0; n_errors = 0; last_stall = 1'b0;
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add3 = mk(1, 1, 2, 1, 1, 3, 1, 0, 0);
    lw2  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0);
    use2 = mk(1, 2, 2, 1, 1, 6, 1, 0, 0);
    do_reset();
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_fwd1", 32'(Forward1), 32'd0);
    check("rst_fwd2", 32'(Forward2), 32'd0);
    check_stats();

    // add r3; add r4,r3,r1 -> 10/00
    cycle(add3);
    cycle(mk(1, 3, 1, 1, 1, 4, 1, 0, 0));
    check("dir_exmem_f1", 32'(Forward1), 32'd2);
    check("dir_exmem_f2", 32'(Forward2), 32'd0);

    // add r3; nop; sub r5,r1,r3 -> 00/01
    cycle(add3);
    cycle(nop);
    cycle(mk(1, 1, 3, 1, 1, 5, 1, 0, 0));
    check("dir_memwb_f1", 32'(Forward1), 32'd0);
    check("dir_memwb_f2", 32'(Forward2), 32'd1);

    // lw r2; add r6,r2,r2 -> one stall, bubble, then 01/01
    do_reset();
    cycle(lw2);
    cycle(use2);
    check("dir_lu_stall", 32'(last_stall), 32'd1);
    check("dir_lu_bub1", 32'(Forward1), 32'd0);
    check("dir_lu_bub2", 32'(Forward2), 32'd0);
    cycle(use2);
    check("dir_lu_nostall", 32'(last_stall), 32'd0);
    check("dir_lu_f1", 32'(Forward1), 32'd1);
    check("dir_lu_f2", 32'(Forward2), 32'd1);
`ifdef HAZARD_STATS_EN
    check("dir_lu_count", StallCount, 32'd1);
`endif

    // r0 never forwarded
    cycle(mk(1, 1, 1, 1, 1, 0, 1, 1, 0));
    cycle(mk(1, 0, 0, 1, 1, 7, 1, 0, 0));
    check("dir_r0_f1", 32'(Forward1), 32'd0);
    check("dir_r0_f2", 32'(Forward2), 32'd0);

    // unused sources never stall or forward
    cycle(lw2);
    cycle(mk(1, 2, 2, 0, 0, 8, 1, 0, 0));
    check("dir_unused_stall", 32'(last_stall), 32'd0);
    check("dir_unused_f1", 32'(Forward1), 32'd0);

    // Flush beats load-use stall
    cycle(lw2);
    cycle(mk(1, 2, 2, 1, 1, 6, 1, 0, 1));
    check("dir_flush_stall", 32'(last_stall), 32'd0);
    check("dir_flush_f1", 32'(Forward1), 32'd0);
    check("dir_flush_f2", 32'(Forward2), 32'd0);

    // Reset in the middle of a stall drops it immediately
    cycle(lw2);
    drive(use2);
    #1;
    check("mid_pre_stall", 32'(Stall), 32'd1);
    RstN = 1'b0;
    #1;
    check("mid_rst_stall", 32'(Stall), 32'd0);
    check("mid_rst_f1", 32'(Forward1), 32'd0);
    check("mid_rst_f2", 32'(Forward2), 32'd0);
    do_reset();
    check_stats();

    // Random traffic over a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      instr_t r;
      r = mk(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 99) < 10));
      cycle(r);
      if (n % 50 == 49) check_stats();
    end
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
